// File: rtl/fb_pixel_if.sv
// fb_pixel_if: pixel stream from the drawing generators and the granted frame-buffer RAM write port
interface fb_pixel_if #(parameter int ADDR_W = 15);
    logic [7:0]        X_loc;
    logic [7:0]        Y_loc;
    logic              WR_en;
    logic [11:0]       RGB;
    logic              wr_ready;
    logic              mem_grant;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_wdata;
    modport master (output X_loc, Y_loc, WR_en, RGB, mem_grant, input wr_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input X_loc, Y_loc, WR_en, RGB, mem_grant, output wr_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/fb_pixel_port.sv
// fb_pixel_port: range-checks generator pixels, queues them and drains into the frame-buffer RAM in granted slots; owns frame clear
module fb_pixel_port #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    fb_pixel_if.slave   pix,
    input  logic        clear_req,
    input  logic [11:0] clear_rgb,
    output logic        busy,
    output logic [15:0] drop_cnt,
    output logic        ovf
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [ADDR_W-1:0] HW   = ADDR_W'(H_RES);

    typedef enum logic {RUN, CLEAR} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [11:0]       q_rgb  [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       count;
    logic [ADDR_W-1:0] clr_addr;
    logic [11:0]       clr_rgb;
    logic              run, in_range, clear_go, push, pop, clr_wr, drop, lost;

    assign run          = state == RUN;
    assign busy         = !run;
    assign pix.wr_ready = run && count < (PW+1)'(FIFO_DEPTH);
    assign in_range     = 32'(pix.X_loc) < H_RES && 32'(pix.Y_loc) < V_RES;
    assign clear_go     = run && clear_req;
    // a clear request beats both the incoming pixel and the drain at the same edge
    assign push         = pix.WR_en && in_range && pix.wr_ready && !clear_req;
    assign lost         = pix.WR_en && in_range && run && !pix.wr_ready && !clear_req;
    assign drop         = pix.WR_en && !push;
    assign pop          = run && !clear_req && pix.mem_grant && count != '0;
    assign clr_wr       = !run && pix.mem_grant;

    always_comb begin
        state_nx = clear_go ? CLEAR : (clr_wr && clr_addr == LAST) ? RUN : state;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= ADDR_W'(pix.Y_loc) * HW + ADDR_W'(pix.X_loc);
            q_rgb[wr_ptr]  <= pix.RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            clr_addr      <= '0;
            clr_rgb       <= '0;
            pix.mem_we    <= 1'b0;
            pix.mem_addr  <= '0;
            pix.mem_wdata <= '0;
            drop_cnt      <= '0;
            ovf           <= 1'b0;
        end else begin
            state      <= state_nx;
            rd_ptr     <= clear_go ? '0 : rd_ptr + PW'(pop);
            wr_ptr     <= clear_go ? '0 : wr_ptr + PW'(push);
            count      <= clear_go ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
            clr_addr   <= clear_go ? '0 : clr_addr + ADDR_W'(clr_wr);
            clr_rgb    <= clear_go ? clear_rgb : clr_rgb;
            pix.mem_we <= pop || clr_wr;
            if (pop || clr_wr) begin
                pix.mem_addr  <= pop ? q_addr[rd_ptr] : clr_addr;
                pix.mem_wdata <= pop ? q_rgb[rd_ptr] : clr_rgb;
            end
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (lost) ovf <= 1'b1;
        end
    end
endmodule

// File: doc/fb_pixel_port.md
# fb_pixel_port

Pixel-write sink for the LCM/VGA frame buffer. Accepts the pixel stream produced by the drawing generators (X/Y location, write enable, 12-bit RGB), range-checks each pixel, converts it to a linear frame-buffer address and queues it in a small FIFO. The FIFO drains into the shared single-port frame-buffer RAM only in slots granted by the display-scan arbiter. The block also provides a whole-frame clear engine and drop/overflow accounting, because generators drive WR_en continuously and ignore back-pressure.

## Interface
- H_RES, 160, visible columns; valid x is 0..H_RES-1
- V_RES, 120, visible rows; valid y is 0..V_RES-1
- FIFO_DEPTH, 4, pending-write entries (power of 2, ≥2)
- ADDR_W, 15, RAM address width; must satisfy H_RES*V_RES ≤ 2^ADDR_W

- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- X_loc  in  8  pixel column
- Y_loc  in  8  pixel row
- WR_en  in  1  pixel valid this cycle
- RGB  in  12  pixel colour {R[11:8],G[7:4],B[3:0]}
- wr_ready  out  1  pixel is accepted at this edge if WR_en=1
- clear_req  in  1  single-cycle pulse that starts a frame clear
- clear_rgb  in  12  clear colour, sampled together with clear_req
- busy  out  1  clear in progress
- mem_grant  in  1  arbiter permits a RAM write in the next cycle
- mem_we  out  1  RAM write strobe (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  12  RAM data (registered)
- drop_cnt  out  16  discarded-pixel count, saturates at 0xFFFF
- ovf  out  1  sticky; set when a pixel is lost because the FIFO is full

## Operation
- States: RUN (normal) and CLEAR. Reset enters RUN.
- Reset values: FIFO empty, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, drop_cnt=0, ovf=0. wr_ready=1 in the first cycle after reset.
- wr_ready = (state==RUN) && (count<FIFO_DEPTH). It is computed from the registered count only; a pop in the same cycle does not free a slot.
- Pixel sampled with WR_en=1:
  - In RUN, x<H_RES, y<V_RES and wr_ready=1: push {addr=y*H_RES+x, RGB}. Address arithmetic is unsigned and ADDR_W wide.
  - Out of range: discard and increment drop_cnt.
  - FIFO full in RUN: discard, increment drop_cnt, set ovf.
  - State is CLEAR: discard and increment drop_cnt.
  - One pixel per cycle increments drop_cnt by exactly 1.
- RUN drain: at an edge with mem_grant=1 and FIFO non-empty, pop the head and register mem_addr/mem_wdata with mem_we=1 for the following cycle. Otherwise mem_we=0, and mem_addr/mem_wdata hold their values.
- Push and pop at the same edge with a non-full FIFO leave count unchanged.
- clear_req in RUN:
  - Latch clear_rgb and flush the FIFO; pending writes are discarded and are not counted as drops.
  - Enter CLEAR with busy=1 and the address counter at 0.
- CLEAR: each edge with mem_grant=1 issues mem_we=1 with mem_addr=counter and mem_wdata=latched colour, then increments the counter. The edge issuing address H_RES*V_RES-1 returns to RUN; busy=0 from the next cycle.
- clear_req during CLEAR is ignored; the clear does not restart.
- clear_req and a valid pixel at the same edge in RUN: the clear wins and the pixel counts as a drop.
- rst_n low at any edge, including mid-clear: return to reset values immediately. No further RAM writes.

## Timing
- Pixel sampled at edge N (accepted), FIFO previously empty, mem_grant=1 at edge N+1: mem_we=1 during cycle N+1..N+2. Latency is 2 cycles from sampling to strobe.
- Throughput is 1 write per granted cycle; sustained input above the grant rate overflows after FIFO_DEPTH accepted pixels.
- Full clear at 100% grant: busy is high for exactly H_RES*V_RES cycles (19200 at defaults).
- mem_grant low only stalls the drain; no state is lost.

## Test plan
- Reset, then pixel (10,2), RGB=0x0F0, grant=1 throughout -> one mem_we pulse with addr=330, data=0x0F0, 2 cycles after sampling; drop_cnt=0.
- Diagonal stream x=y=0..120 repeating, WR_en=1 constantly, grant=1 -> addresses 0,161,…,19159 written; (120,120) dropped once per 121 cycles; ovf stays 0.
- grant=0, 6 consecutive valid pixels -> first 4 queued; wr_ready=0 after the 4th; drop_cnt=2, ovf=1. Then grant=1 -> 4 writes in push order, wr_ready returns to 1.
- clear_req with clear_rgb=0x000 while 3 entries are queued, grant=1 -> queue discarded, 19200 writes addr 0..19199 data 0x000, busy high for 19200 cycles. Pixels presented during the clear are counted in drop_cnt.
- Grant toggling 1/0 during clear -> 19200 writes over about 38400 cycles; a second clear_req mid-clear is ignored.
- rst_n low for 1 cycle mid-clear -> mem_we=0 next cycle; busy=0, drop_cnt=0, ovf=0; normal pixel writes resume.
